exe_seq_ctrl: RTL and testbench
===============================

# exe_seq_ctrl

Execute-stage sequencer for the combinational 64-bit ALU. It accepts one decoded operation per cycle from ID/EX, latches the operands and opcode onto the ALU inputs, and holds them for an opcode-dependent latency: 1 cycle for simple ops, longer for multiply, divide and FP add. It then captures the ALU outputs into the EX/MEM-facing result registers and stalls the front end while a multi-cycle operation occupies the ALU.

## Interface
Parameters:
- MUL_LAT, 3, cycles for opcode 5'h0F (range 1..15)
- DIV_LAT, 8, cycles for opcode 5'h10 (range 1..15)
- FP_LAT, 2, cycles for opcodes 5'h0C, 5'h0D (range 1..15)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous cancel of the in-flight operation
- id_valid  in  1  operation offered this cycle
- id_operation  in  5  ALU opcode
- id_op1, id_op2  in  64  operands (rs; rt/immediate)
- id_shamt  in  5  shift amount
- stall  out  1  combinational; 1 = do not advance ID/EX
- alu_operation  out  5  registered opcode driven to ALU
- alu_op1, alu_op2  out  64  registered operands to ALU
- alu_shamt  out  5  registered shift amount to ALU
- alu_result  in  64  ALU result
- alu_zero, alu_overflow  in  1  ALU flags
- exe_valid  out  1  one-cycle pulse, result registers hold a new result
- exe_result  out  64  captured result
- exe_zero, exe_overflow  out  1  captured flags
- exe_div0  out  1  divide-by-zero flag, qualified by exe_valid

## Operation
- States: IDLE, BUSY. Down-counter cnt is 4 bits wide.
- Accept: id_valid && !stall && !flush. At the accept edge:
  - latch the opcode, operands and shamt onto the alu_* outputs
  - load cnt with the latency L for the opcode
  - enter BUSY
- Latency L: 5'h0F→MUL_LAT, 5'h10→DIV_LAT, 5'h0C/5'h0D→FP_LAT. All other opcodes, including 5'h00 and undefined 5'h11–5'h1F, use L=1.
- In BUSY, cnt decrements each edge.
- At the edge where cnt==1, capture alu_result, alu_zero and alu_overflow into the exe_* registers and pulse exe_valid for the following cycle.
  - If no accept occurs at the same edge, go to IDLE and set alu_operation to 5'h00 (ALU NOP). Operand registers keep their values.
  - If an accept occurs at the same edge, reload cnt and stay in BUSY (back-to-back issue).
- stall = BUSY && cnt>1. stall is never asserted in IDLE or on the final cycle.
- flush: at the edge, enter IDLE, clear cnt, set alu_operation to 0 and suppress the pending capture. exe_valid is 0 in the next cycle. A simultaneous id_valid is not accepted (flush wins).
- exe_* registers hold their value between pulses. exe_valid is 0 whenever no capture occurred at the preceding edge.

## Timing
- Reset values: all outputs 0, including the alu_* registers, exe_* registers and stall. State is IDLE and cnt is 0.
- Accept at edge k: exe_valid is high in the cycle after edge k+L.
- stall is high in the cycles between edges k and k+L-1.
- Single-cycle ops issue at full throughput, one result per cycle.
- Reset asserted mid-operation: all state and outputs return to reset values immediately. No exe_valid is produced for the aborted operation.

## Configuration
- EXE_SEQ_DIV0_TRAP_EN defined:
  - Opcode 5'h10 with id_op2[31:0]==0 uses L=1, and alu_operation is driven 5'h00 instead of 5'h10.
  - The capture stores exe_result=0, exe_zero=1, exe_overflow=0 and exe_div0=1.
  - exe_div0 is 0 for all other captures.
- EXE_SEQ_DIV0_TRAP_EN undefined:
  - Divide by zero is issued normally with DIV_LAT.
  - exe_div0 is tied to 0.

## Test plan
- Reset, then id_valid with opcode 5'h03, op1=5, op2=7: stall stays 0; exe_valid pulses exactly once, 2 cycles after the offer cycle, with exe_result=12.
- Opcode 5'h0F, op1=6, op2=9, MUL_LAT=3, followed immediately by opcode 5'h02: stall is 1 for 2 cycles. The OR is accepted on the multiply's final edge. exe_result=54, then the OR result on consecutive exe_valid pulses.
- Opcode 5'h10, op1=100, op2=7, DIV_LAT=8: stall is 1 for 7 cycles. exe_result[31:0]=14, exe_result[63:32]=2.
- Opcode 5'h10 with op2=0 and EXE_SEQ_DIV0_TRAP_EN defined: L=1, exe_div0=1, exe_result=0, exe_zero=1. Without the macro: 8-cycle latency and exe_div0=0.
- Start a divide, assert flush on its 4th busy cycle together with id_valid: no exe_valid follows, stall drops the next cycle, the offered op is not accepted, and alu_operation=0.
- Assert rst asynchronously mid-multiply: stall, exe_valid and alu_operation go to 0 without waiting for a clock edge, and no result is produced afterwards.

Source files
------------

// File: rtl/exe_seq_ctrl.sv
// Execute-stage sequencer: holds an op on the combinational ALU for its latency, then captures the result.
// Optional divide-by-zero trap enabled by defining EXE_SEQ_DIV0_TRAP_EN.
module exe_seq_ctrl #(
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 8,
  parameter int FP_LAT  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        id_valid,
  input  logic [4:0]  id_operation,
  input  logic [63:0] id_op1,
  input  logic [63:0] id_op2,
  input  logic [4:0]  id_shamt,
  output logic        stall,
  output logic [4:0]  alu_operation,
  output logic [63:0] alu_op1,
  output logic [63:0] alu_op2,
  output logic [4:0]  alu_shamt,
  input  logic [63:0] alu_result,
  input  logic        alu_zero,
  input  logic        alu_overflow,
  output logic        exe_valid,
  output logic [63:0] exe_result,
  output logic        exe_zero,
  output logic        exe_overflow,
  output logic        exe_div0
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [3:0] lat;
  logic       last, accept, div0_trap;

  assign last   = (state == BUSY) && (cnt == 4'd1);
  assign stall  = (state == BUSY) && (cnt > 4'd1);
  assign accept = id_valid && !stall && !flush;

`ifdef EXE_SEQ_DIV0_TRAP_EN
  assign div0_trap = (id_operation == 5'h10) && (id_op2[31:0] == 32'd0);
`else
  assign div0_trap = 1'b0;
`endif

  always_comb begin
    lat = 4'd1;
    if (!div0_trap) begin
      case (id_operation)
        5'h0F:        lat = 4'(MUL_LAT);
        5'h10:        lat = 4'(DIV_LAT);
        5'h0C, 5'h0D: lat = 4'(FP_LAT);
        default:      lat = 4'd1;
      endcase
    end
  end

  // flush beats accept; an accept on the final edge reloads for back-to-back issue
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (flush) begin
      state_nxt = IDLE;
      cnt_nxt   = 4'd0;
    end else if (accept) begin
      state_nxt = BUSY;
      cnt_nxt   = lat;
    end else if (last) begin
      state_nxt = IDLE;
      cnt_nxt   = 4'd0;
    end else if (state == BUSY) begin
      cnt_nxt   = cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_operation <= 5'h00;
      alu_op1       <= 64'd0;
      alu_op2       <= 64'd0;
      alu_shamt     <= 5'd0;
    end else if (flush) begin
      alu_operation <= 5'h00;
    end else if (accept) begin
      alu_operation <= div0_trap ? 5'h00 : id_operation;
      alu_op1       <= id_op1;
      alu_op2       <= id_op2;
      alu_shamt     <= id_shamt;
    end else if (last) begin
      alu_operation <= 5'h00;
    end
  end

`ifdef EXE_SEQ_DIV0_TRAP_EN
  logic trap_pend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      trap_pend <= 1'b0;
    else if (accept)
      trap_pend <= div0_trap;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exe_valid    <= 1'b0;
      exe_result   <= 64'd0;
      exe_zero     <= 1'b0;
      exe_overflow <= 1'b0;
      exe_div0     <= 1'b0;
    end else begin
      exe_valid <= last && !flush;
      if (last && !flush) begin
        exe_result   <= trap_pend ? 64'd0 : alu_result;
        exe_zero     <= trap_pend ? 1'b1  : alu_zero;
        exe_overflow <= trap_pend ? 1'b0  : alu_overflow;
        exe_div0     <= trap_pend;
      end
    end
  end
`else
  assign exe_div0 = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exe_valid    <= 1'b0;
      exe_result   <= 64'd0;
      exe_zero     <= 1'b0;
      exe_overflow <= 1'b0;
    end else begin
      exe_valid <= last && !flush;
      if (last && !flush) begin
        exe_result   <= alu_result;
        exe_zero     <= alu_zero;
        exe_overflow <= alu_overflow;
      end
    end
  end
`endif

endmodule

// File: tb/tb_exe_seq_ctrl.sv
// Bench for exe_seq_ctrl: directed ops, a cycle-level scoreboard model and literal spot checks.
module tb_exe_seq_ctrl;
  localparam int MUL_L = 3, DIV_L = 8, FP_L = 2;

  logic        clk = 0, rst = 1, flush = 0, id_valid = 0;
  logic [4:0]  id_operation = 0, id_shamt = 0;
  logic [63:0] id_op1 = 0, id_op2 = 0;
  logic        stall, exe_valid, exe_zero, exe_overflow, exe_div0;
  logic [4:0]  alu_operation, alu_shamt;
  logic [63:0] alu_op1, alu_op2, alu_result, exe_result;
  logic        alu_zero, alu_overflow;

  int checks = 0, errors = 0, ecnt = 0;

  exe_seq_ctrl #(.MUL_LAT(MUL_L), .DIV_LAT(DIV_L), .FP_LAT(FP_L)) dut (
    .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid),
    .id_operation(id_operation), .id_op1(id_op1), .id_op2(id_op2), .id_shamt(id_shamt),
    .stall(stall), .alu_operation(alu_operation), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_shamt(alu_shamt), .alu_result(alu_result), .alu_zero(alu_zero),
    .alu_overflow(alu_overflow), .exe_valid(exe_valid), .exe_result(exe_result),
    .exe_zero(exe_zero), .exe_overflow(exe_overflow), .exe_div0(exe_div0));

  always #5 clk = ~clk;
  always @(posedge clk) ecnt <= ecnt + 1;

  // Stand-in combinational ALU: {overflow, result}
  function automatic logic [64:0] alu_f(input logic [4:0] op, input logic [63:0] a, b, input logic [4:0] sh);
    logic [63:0] r;
    logic ov;
    ov = 1'b0;
    case (op)
      5'h00: r = 64'd0;
      5'h02: r = a | b;
      5'h03: begin r = a + b; ov = (a[63] == b[63]) && (r[63] != a[63]); end
      5'h0C, 5'h0D: r = a + b + 64'd1;
      5'h0F: r = a * b;
      5'h10: r = (b[31:0] == 32'd0) ? '1 : {a[31:0] % b[31:0], a[31:0] / b[31:0]};
      default: r = a << sh;
    endcase
    return {ov, r};
  endfunction

  assign {alu_overflow, alu_result} = alu_f(alu_operation, alu_op1, alu_op2, alu_shamt);
  assign alu_zero = (alu_result == 64'd0);

  function automatic bit is_trap(input logic [4:0] op, input logic [63:0] b);
`ifdef EXE_SEQ_DIV0_TRAP_EN
    return (op == 5'h10) && (b[31:0] == 32'd0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int lat_of(input logic [4:0] op, input logic [63:0] b);
    if (is_trap(op, b)) return 1;
    case (op)
      5'h0F: return MUL_L;
      5'h10: return DIV_L;
      5'h0C, 5'h0D: return FP_L;
      default: return 1;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: one op in flight, captured at absolute edge m_done
  bit          m_busy;
  int          m_done;
  logic [63:0] m_res;
  logic        m_zero, m_ovf, m_div0;
  logic        x_valid, x_zero, x_ovf, x_div0;
  logic [63:0] x_res, x_op1, x_op2;
  logic [4:0]  x_aop, x_sh;

  always @(negedge clk) begin
    logic x_stall, fin, acc;
    logic [64:0] f;
    if (rst) begin
      m_busy = 0; m_done = 0; m_res = 0; m_zero = 0; m_ovf = 0; m_div0 = 0;
      x_valid = 0; x_res = 0; x_zero = 0; x_ovf = 0; x_div0 = 0;
      x_aop = 0; x_op1 = 0; x_op2 = 0; x_sh = 0;
    end
    x_stall = m_busy && (m_done > ecnt + 1);
    chk("stall", stall, x_stall);
    chk("exe_valid", exe_valid, x_valid);
    chk("exe_result", exe_result, x_res);
    chk("exe_flags", {exe_zero, exe_overflow, exe_div0}, {x_zero, x_ovf, x_div0});
    chk("alu_operation", alu_operation, x_aop);
    chk("alu_operands", {alu_op1 ^ alu_op2, 59'd0, alu_shamt}, {x_op1 ^ x_op2, 59'd0, x_sh});
    if (!rst) begin
      fin = m_busy && (m_done == ecnt + 1);
      acc = id_valid && !x_stall && !flush;
      x_valid = !flush && fin;
      if (x_valid) begin
        x_res = m_res; x_zero = m_zero; x_ovf = m_ovf; x_div0 = m_div0;
      end
      if (flush) begin
        m_busy = 0; x_aop = 0;
      end else if (acc) begin
        m_busy = 1;
        m_done = ecnt + 1 + lat_of(id_operation, id_op2);
        x_op1 = id_op1; x_op2 = id_op2; x_sh = id_shamt;
        if (is_trap(id_operation, id_op2)) begin
          x_aop = 0; m_res = 0; m_zero = 1; m_ovf = 0; m_div0 = 1;
        end else begin
          x_aop = id_operation;
          f = alu_f(id_operation, id_op1, id_op2, id_shamt);
          m_res = f[63:0]; m_ovf = f[64]; m_zero = (f[63:0] == 64'd0); m_div0 = 0;
        end
      end else if (fin) begin
        m_busy = 0; x_aop = 0;
      end
    end
  end

  // Offer an op until it is taken; nst counts cycles it sat stalled
  task automatic issue(input logic [4:0] op, input logic [63:0] a, b, input logic [4:0] sh, output int nst);
    nst = 0;
    id_valid = 1; id_operation = op; id_op1 = a; id_op2 = b; id_shamt = sh;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!stall) break;
      nst++;
    end
    chk("issue_timeout", stall, 1'b0);
    @(posedge clk); #1;
    id_valid = 0;
  endtask

  task automatic wait_res(input string name, input logic [63:0] exp, output int cyc);
    bit seen;
    seen = 0; cyc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cyc++;
      if (exe_valid) begin seen = 1; break; end
    end
    chk({name, "_seen"}, seen, 1'b1);
    if (seen) chk(name, exe_result, exp);
  endtask

  task automatic count_pulses(input string name, input int n);
    int p;
    p = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (exe_valid) p++;
    end
    chk(name, p, 0);
  endtask

  initial begin
    int nst, cyc;
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int nst, cyc;
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // simple add: no stall, pulse 2 cycles after offer
    issue(5'h03, 64'd5, 64'd7, 5'd0, nst);
    chk("add_stall", nst, 0);
    wait_res("add_result", 64'd12, cyc);
    chk("add_latency", cyc, 2);
    repeat (2) @(posedge clk); #1;

    // multiply then OR back-to-back
    issue(5'h0F, 64'd6, 64'd9, 5'd0, nst);
    chk("mul_offer_stall", nst, 0);
    issue(5'h02, 64'hF0, 64'h0F, 5'd0, nst);
    chk("mul_stall_cycles", nst, 2);
    wait_res("mul_result", 64'd54, cyc);
    wait_res("or_result", 64'hFF, cyc);
    chk("or_consecutive", cyc, 1);
    repeat (2) @(posedge clk); #1;

    // divide 100/7
    issue(5'h10, 64'd100, 64'd7, 5'd0, nst);
    issue(5'h03, 64'd1, 64'd1, 5'd0, nst);
    chk("div_stall_cycles", nst, 7);
    wait_res("div_result", {32'd2, 32'd14}, cyc);
    wait_res("add2_result", 64'd2, cyc);
    repeat (2) @(posedge clk); #1;

    // divide by zero
    issue(5'h10, 64'd50, 64'd0, 5'd0, nst);
    issue(5'h03, 64'd3, 64'd3, 5'd0, nst);
`ifdef EXE_SEQ_DIV0_TRAP_EN
    chk("div0_stall_cycles", nst, 0);
    wait_res("div0_result", 64'd0, cyc);
    chk("div0_flags", {exe_zero, exe_div0}, 2'b11);
`else
    chk("div0_stall_cycles", nst, 7);
    wait_res("div0_result", 64'hFFFF_FFFF_FFFF_FFFF, cyc);
    chk("div0_flags", {exe_zero, exe_div0}, 2'b00);
`endif
    wait_res("add3_result", 64'd6, cyc);

    // FP add, undefined opcode (shift in stand-in ALU), signed overflow, full-rate adds
    issue(5'h0C, 64'd3, 64'd4, 5'd0, nst);
    issue(5'h15, 64'd1, 64'd0, 5'd4, nst);
    chk("fp_stall_cycles", nst, 1);
    wait_res("fp_result", 64'd8, cyc);
    wait_res("undef_result", 64'd16, cyc);
    issue(5'h03, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 5'd0, nst);
    for (int i = 0; i < 4; i++) begin
      issue(5'h03, 64'(i), 64'(10 * i), 5'd0, nst);
      chk("throughput_stall", nst, 0);
    end
    repeat (3) @(posedge clk); #1;

    // flush on 4th busy cycle of a divide, with an op offered
    issue(5'h10, 64'd100, 64'd7, 5'd0, nst);
    repeat (3) @(posedge clk); #1;
    flush = 1; id_valid = 1; id_operation = 5'h03; id_op1 = 64'd1; id_op2 = 64'd2;
    @(posedge clk); #1;
    flush = 0; id_valid = 0;
    @(negedge clk);
    chk("flush_stall", stall, 1'b0);
    chk("flush_aluop", alu_operation, 5'h00);
    count_pulses("flush_no_result", 12);

    // async reset mid-multiply
    @(posedge clk); #1;
    issue(5'h0F, 64'd11, 64'd3, 5'd0, nst);
    @(posedge clk); #3;
    rst = 1;
    #1;
    chk("rst_async_stall", stall, 1'b0);
    chk("rst_async_valid", exe_valid, 1'b0);
    chk("rst_async_aluop", alu_operation, 5'h00);
    repeat (2) @(posedge clk); #1;
    rst = 0;
    count_pulses("rst_no_result", 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
